// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, run/pause/freeze FSM, 1 kHz tick prescaler,
// clear/lap handling and display selection for the ms counter datapath.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned WIDTH     = 20,
    parameter int unsigned MAX_COUNT = 999999
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_n_i,
    input  logic             stop_n_i,
    input  logic             lap_n_i,
    input  logic             clear_n_i,
    input  logic [WIDTH-1:0] ms_count_i,
    output logic             ms_tick_o,
    output logic             count_en_o,
    output logic             count_clr_o,
    output logic [WIDTH-1:0] lap_value_o,
    output logic [WIDTH-1:0] display_value_o,
    output logic [1:0]       state_o,
    output logic             overflow_o
);

    localparam int unsigned       DIV        = CLK_HZ / TICK_HZ;
    localparam int unsigned       PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0]  COUNT_LAST = WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StPaused = 2'b10,
        StFrozen = 2'b11
    } state_e;

    // Button bit order: 0 start, 1 stop, 2 lap, 3 clear.
    logic [3:0] btn_n;
    logic [3:0] sync1_q, sync2_q, prev_q, press_q;
    logic [1:0] settle_q;
    logic       settled;

    assign btn_n   = {clear_n_i, lap_n_i, stop_n_i, start_n_i};
    assign settled = (settle_q == 2'd3);

    // Edges are ignored until the chain holds real pin samples, so a button held
    // through reset release does not look like a fresh press.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            prev_q   <= '1;
            press_q  <= '0;
            settle_q <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            press_q <= settled ? (prev_q & ~sync2_q) : 4'b0000;
            if (!settled) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    logic act_clr, act_stop, act_start, act_lap;

    always_comb begin
        act_clr   = press_q[3];
        act_stop  = press_q[1] & ~press_q[3];
        act_start = press_q[0] & ~press_q[1] & ~press_q[3];
        act_lap   = press_q[2] & ~press_q[0] & ~press_q[1] & ~press_q[3];
    end

    state_e           state_q;
    logic [PW-1:0]    presc_q;
    logic [WIDTH-1:0] lap_q;
    logic             ovf_q, tick_q, clr_q;
    logic             tick_due, at_max;

    assign count_en_o = ((state_q == StRun) || (state_q == StFrozen)) && !ovf_q;
    assign tick_due   = count_en_o && (presc_q == PRESC_LAST);
    assign at_max     = (ms_count_i == COUNT_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            presc_q <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
            tick_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            clr_q  <= 1'b0;
            if (act_clr) begin
                state_q <= StIdle;
                presc_q <= '0;
                lap_q   <= '0;
                ovf_q   <= 1'b0;
                clr_q   <= 1'b1;
            end else begin
                if (count_en_o) begin
                    presc_q <= tick_due ? '0 : presc_q + PW'(1);
                end
                // A tick that would push the count past the limit is swallowed.
                if (tick_due && at_max) begin
                    ovf_q   <= 1'b1;
                    state_q <= StPaused;
                end else begin
                    tick_q <= tick_due;
                    case (state_q)
                        StIdle: begin
                            if (act_start) state_q <= StRun;
                        end
                        StRun: begin
                            if (act_stop) begin
                                state_q <= StPaused;
                            end else if (act_lap) begin
                                state_q <= StFrozen;
                                lap_q   <= ms_count_i;
                            end
                        end
                        StFrozen: begin
                            if (act_stop) begin
                                state_q <= StPaused;
                            end else if (act_lap) begin
                                state_q <= StRun;
                            end
                        end
                        StPaused: begin
                            if (act_start && !ovf_q) state_q <= StRun;
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign ms_tick_o       = tick_q;
    assign count_clr_o     = clr_q;
    assign lap_value_o     = lap_q;
    assign overflow_o      = ovf_q;
    assign state_o         = state_q;
    assign display_value_o = (state_q == StFrozen) ? lap_q : ms_count_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and MAX_COUNT=5; a small ms counter model
// closes the loop, or the count can be driven by hand.
module tb_stopwatch_ctrl;

    localparam int unsigned W = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_n, stop_n, lap_n, clear_n;
    logic [W-1:0] ms_count;
    logic         ms_tick, count_en, count_clr, overflow;
    logic [W-1:0] lap_value, display_value;
    logic [1:0]   state;

    logic         use_model;
    logic [W-1:0] ms_man;
    logic [W-1:0] cnt_q;

    int n_checks = 0;
    int n_errors = 0;
    int seen;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ   (10),
        .TICK_HZ  (1),
        .WIDTH    (W),
        .MAX_COUNT(5)
    ) u_dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_n_i      (start_n),
        .stop_n_i       (stop_n),
        .lap_n_i        (lap_n),
        .clear_n_i      (clear_n),
        .ms_count_i     (ms_count),
        .ms_tick_o      (ms_tick),
        .count_en_o     (count_en),
        .count_clr_o    (count_clr),
        .lap_value_o    (lap_value),
        .display_value_o(display_value),
        .state_o        (state),
        .overflow_o     (overflow)
    );

    // External ms counter
    always @(posedge clk or posedge reset) begin
        if (reset)          cnt_q <= '0;
        else if (count_clr) cnt_q <= '0;
        else if (ms_tick)   cnt_q <= cnt_q + 1'b1;
    end

    assign ms_count = use_model ? cnt_q : ms_man;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        {start_n, stop_n, lap_n, clear_n} = 4'b1111;
        use_model = 1'b1;
        ms_man = '0;
        step(2);
        check_eq("rst_state", state, 0);
        check_eq("rst_en", count_en, 0);
        check_eq("rst_tick", ms_tick, 0);
        check_eq("rst_clr", count_clr, 0);
        check_eq("rst_lap", lap_value, 0);
        check_eq("rst_ovf", overflow, 0);
        reset = 1'b0;
        step(5);

        // Start: pin sampled low at edge 1, RUN after edge 4
        start_n = 1'b0;
        step(3);
        check_eq("start_wait", state, 0);
        step(1);
        check_eq("start_run", state, 1);
        check_eq("start_en", count_en, 1);
        start_n = 1'b1;
        step(9);
        check_eq("tick1_early", ms_tick, 0);
        step(1);
        check_eq("tick1", ms_tick, 1);
        step(1);
        check_eq("tick1_width", ms_tick, 0);
        step(9);
        check_eq("tick2", ms_tick, 1);

        // Stop lands where the prescaler reads 4; it resumes from 5
        step(1);
        stop_n = 1'b0;
        step(4);
        check_eq("stop_paused", state, 2);
        check_eq("stop_en", count_en, 0);
        stop_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (ms_tick) seen++;
        end
        check_eq("paused_ticks", seen, 0);
        check_eq("paused_disp", display_value, 2);
        start_n = 1'b0;
        step(4);
        check_eq("resume_run", state, 1);
        start_n = 1'b1;
        step(4);
        check_eq("resume_early", ms_tick, 0);
        step(1);
        check_eq("resume_tick", ms_tick, 1);

        // Lap freeze at 37, live count moves on
        use_model = 1'b0;
        ms_man = 37;
        lap_n = 1'b0;
        step(4);
        check_eq("lap_frozen", state, 3);
        check_eq("lap_value", lap_value, 37);
        lap_n = 1'b1;
        ms_man = 38;
        check_eq("lap_disp", display_value, 37);
        step(6);
        check_eq("frozen_tick", ms_tick, 1);
        lap_n = 1'b0;
        step(4);
        check_eq("unfreeze_run", state, 1);
        check_eq("unfreeze_disp", display_value, 38);
        check_eq("unfreeze_lap", lap_value, 37);
        lap_n = 1'b1;

        // Start beats lap; start does nothing in RUN
        {start_n, lap_n} = 2'b00;
        step(4);
        check_eq("startlap_state", state, 1);
        check_eq("startlap_lap", lap_value, 37);
        {start_n, lap_n} = 2'b11;
        step(2);
        stop_n = 1'b0;
        step(4);
        check_eq("stop2_paused", state, 2);
        stop_n = 1'b1;
        step(2);

        // Clear beats start
        {start_n, clear_n} = 2'b00;
        step(3);
        check_eq("clr_pre_state", state, 2);
        check_eq("clr_pre_pulse", count_clr, 0);
        step(1);
        check_eq("clr_state", state, 0);
        check_eq("clr_pulse", count_clr, 1);
        check_eq("clr_lap", lap_value, 0);
        step(1);
        check_eq("clr_pulse_end", count_clr, 0);
        check_eq("clr_idle", state, 0);
        {start_n, clear_n} = 2'b11;
        use_model = 1'b1;
        step(5);

        // Overflow at MAX_COUNT=5
        start_n = 1'b0;
        step(4);
        check_eq("ovf_run", state, 1);
        start_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            step(1);
            if (ms_tick) seen++;
        end
        check_eq("ovf_ticks", seen, 5);
        check_eq("ovf_count", ms_count, 5);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_state", state, 2);
        check_eq("ovf_en", count_en, 0);
        start_n = 1'b0;
        step(4);
        check_eq("ovf_start_ign", state, 2);
        start_n = 1'b1;
        step(2);
        clear_n = 1'b0;
        step(4);
        check_eq("ovf_clr_state", state, 0);
        check_eq("ovf_clr_flag", overflow, 0);
        check_eq("ovf_clr_pulse", count_clr, 1);
        clear_n = 1'b1;
        step(5);

        // Reset while FROZEN with prescaler at 7
        use_model = 1'b0;
        ms_man = 3;
        start_n = 1'b0;
        step(4);
        check_eq("r6_run", state, 1);
        start_n = 1'b1;
        lap_n = 1'b0;
        step(4);
        check_eq("r6_frozen", state, 3);
        check_eq("r6_lap", lap_value, 3);
        step(3);
        reset = 1'b1;
        start_n = 1'b0;
        #2;
        check_eq("r6_state", state, 0);
        check_eq("r6_en", count_en, 0);
        check_eq("r6_lap0", lap_value, 0);
        check_eq("r6_tick", ms_tick, 0);
        check_eq("r6_clr", count_clr, 0);
        check_eq("r6_ovf", overflow, 0);
        step(2);
        reset = 1'b0;
        lap_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (count_clr || state != 2'b00) seen++;
        end
        check_eq("held_no_pulse", seen, 0);
        check_eq("held_en", count_en, 0);
        start_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control and sequencing block for the lab stopwatch millisecond counter datapath.
- Synchronises and edge-detects four active-low pushbuttons and runs the stopwatch state machine.
- Generates the 1 kHz count-enable tick, clear strobe and lap capture; selects the value shown on the display.
- Sits between the board buttons and the ms counter / display decoder.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1000, tick rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be an integer ≥ 2.
- WIDTH, 20, width of the count, lap and display values.
- MAX_COUNT, 999999, last legal count value; the count never passes this value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_n  in  1  start button, active-low, asynchronous to clk.
- stop_n  in  1  stop button, active-low, asynchronous.
- lap_n  in  1  lap/freeze button, active-low, asynchronous.
- clear_n  in  1  clear button, active-low, asynchronous.
- ms_count  in  WIDTH  current value fed back from the ms counter.
- ms_tick  out  1  one-cycle increment strobe to the ms counter.
- count_en  out  1  high while the stopwatch is counting.
- count_clr  out  1  one-cycle synchronous clear strobe to the ms counter.
- lap_value  out  WIDTH  captured lap time.
- display_value  out  WIDTH  value to display.
- state  out  2  encoding: IDLE=00, RUN=01, PAUSED=10, FROZEN=11.
- overflow  out  1  sticky flag: count reached MAX_COUNT.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; prescaler=0; lap_value=0; overflow=0.
  - ms_tick=0, count_clr=0, count_en=0.
  - Synchroniser flops preset to 1 (buttons released).
- Input conditioning:
  - Each button passes through a 2-flop synchroniser, then a falling-edge detector, giving a 1-cycle press pulse per press.
  - Timing: pin low at edge k → pulse high in the cycle after edge k+2 → state changes at edge k+3.
  - A held button produces one pulse only. No debounce; debouncing is external.
- Simultaneous pulses are prioritised: clear > stop > start > lap. Only the highest-priority pulse acts; the others are discarded.
- FSM transitions (unlisted pulses are ignored):
  - IDLE: start → RUN.
  - RUN: stop → PAUSED; lap → FROZEN with lap_value <= ms_count in the same edge.
  - FROZEN: lap → RUN (display goes live again, lap_value retained); stop → PAUSED.
  - PAUSED: start → RUN, unless overflow=1, in which case start is ignored.
  - Any state: clear → IDLE.
- Clear action:
  - count_clr pulses high exactly 1 cycle, registered, on the edge the FSM enters IDLE via clear.
  - Same edge: prescaler=0, lap_value=0, overflow=0.
- Tick generation:
  - count_en = (state==RUN || state==FROZEN) && !overflow.
  - While count_en=1, the prescaler counts 0..DIV-1 and wraps.
  - ms_tick is registered and high for the 1 cycle following the edge where prescaler==DIV-1. Period is exactly DIV cycles.
  - In PAUSED the prescaler holds its value, so the sub-ms fraction is preserved on resume. In IDLE it is 0.
- Overflow:
  - If a tick is due while ms_count==MAX_COUNT, the tick is suppressed, overflow is set, and state moves to PAUSED (from FROZEN as well).
  - The count therefore never exceeds MAX_COUNT. Only clear or reset releases overflow.
- display_value is combinational: lap_value when state==FROZEN, otherwise ms_count.
- Reset mid-count: all state is dropped immediately; count_clr is not pulsed (the counter has its own reset).
- Implementation has no latches and no combinational path from button pins to outputs.

Test Plan:
- Reset, then release; CLK_HZ=10, TICK_HZ=1 (DIV=10); press start → state=01 three edges after the pin falls; ms_tick every 10 cycles; count_en=1.
- RUN, stop pressed at prescaler=4 → PAUSED, no ticks; start → first tick after 5 more cycles, confirming the fraction is kept.
- RUN, ms_count=37, press lap → state=11, lap_value=37, display=37 while ticks continue; press lap again → state=01, display=ms_count, lap_value still 37.
- start_n and clear_n fall on the same cycle in PAUSED → state=00, count_clr high exactly 1 cycle, start ignored; start_n and lap_n together in RUN → no lap capture, state stays 01.
- MAX_COUNT=5, counter model fed back, run → ticks stop at ms_count=5; overflow=1; state=10; start ignored; clear → overflow=0, state=00.
- Assert reset in FROZEN with prescaler=7 → all outputs 0 asynchronously, state=00, no count_clr pulse; holding a button low through reset release → no spurious pulse.
